// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate codes, PIPE status codes, OS types, Tx sub-FSM states.
// Pure declarations; no latency or backpressure.
package ltssm_pkg;

  typedef enum logic [3:0] {
    detectQuiet                  = 4'd0,
    detectActive                 = 4'd1,
    pollingActive                = 4'd2,
    pollingConfiguration         = 4'd3,
    configurationLinkWidthStart  = 4'd4,
    configurationLinkWidthAccept = 4'd5,
    configurationLanenumWait     = 4'd6,
    configurationLanenumAccept   = 4'd7,
    configurationComplete        = 4'd8,
    configurationIdle            = 4'd9,
    L0                           = 4'd10
  } substate_e;

  localparam logic [3:0] SUB_NONE          = 4'hF;
  localparam logic [2:0] RXSTATUS_DETECTED = 3'b011;
  localparam logic       OS_TS1            = 1'b0;
  localparam logic       OS_TS2            = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_QUIET, ST_DET_START, ST_DET_WAIT, ST_DET_RPT,
    ST_POLL_ACT, ST_POLL_CFG, ST_DONE
  } tx_state_e;

  function automatic tx_state_e entry_state(input logic [3:0] sub);
    case (sub)
      4'd0:    return ST_QUIET;
      4'd1:    return ST_DET_START;
      4'd2:    return ST_POLL_ACT;
      4'd3:    return ST_POLL_CFG;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ltssm_tx_detect_polling_if.sv
// Coordinator / PIPE / OS-generator signals of the Tx Detect+Polling sub-LTSSM.
// slave = the sub-LTSSM, master = its environment.
interface ltssm_tx_detect_polling_if #(parameter int MAXLANES = 16);
  logic [3:0]            substateTx;
  logic [MAXLANES-1:0]   phyStatus;
  logic [3*MAXLANES-1:0] rxStatus;
  logic                  ts2Received;
  logic                  osDone;
  logic                  txDetectRx;
  logic                  osReq;
  logic                  osType;
  logic                  finishTx;
  logic [3:0]            gotoTx;
  logic [4:0]            numberOfDetectedLanesOut;
  logic                  writeNumberOfDetectedLanes;

  modport master (
    output substateTx, phyStatus, rxStatus, ts2Received, osDone,
    input  txDetectRx, osReq, osType, finishTx, gotoTx,
           numberOfDetectedLanesOut, writeNumberOfDetectedLanes
  );

  modport slave (
    input  substateTx, phyStatus, rxStatus, ts2Received, osDone,
    output txDetectRx, osReq, osType, finishTx, gotoTx,
           numberOfDetectedLanesOut, writeNumberOfDetectedLanes
  );
endinterface

// File: rtl/ltssm_tx_detect_polling_lane_detect_count.sv
// Folds this cycle's first PhyStatus per lane (with RxStatus=detected) into the
// detected mask and pop-counts it. Combinational, no backpressure.
module lane_detect_count
  import ltssm_pkg::*;
#(
  parameter int MAXLANES = 16
) (
  input  logic [MAXLANES-1:0]   phy_status_i,
  input  logic [3*MAXLANES-1:0] rx_status_i,
  input  logic [MAXLANES-1:0]   seen_i,
  input  logic [MAXLANES-1:0]   det_i,
  output logic [MAXLANES-1:0]   det_o,
  output logic [4:0]            count_o
);

  always_comb begin
    det_o   = det_i;
    count_o = '0;
    for (int i = 0; i < MAXLANES; i++) begin
      if (phy_status_i[i] && !seen_i[i] && rx_status_i[3*i +: 3] == RXSTATUS_DETECTED)
        det_o[i] = 1'b1;
      count_o = count_o + 5'(det_o[i]);
    end
  end

endmodule

// File: rtl/ltssm_tx_detect_polling.sv
// Tx sub-LTSSM for Detect/Polling: receiver detect, TS1/TS2 requests, exit decisions.
// Registered outputs; substate change takes effect next cycle; no backpressure.
module ltssm_tx_detect_polling
  import ltssm_pkg::*;
#(
  parameter int MAXLANES            = 16,
  parameter int QUIET_CYCLES        = 1200,
  parameter int POLL_ACTIVE_TIMEOUT = 2400,
  parameter int POLL_CONFIG_TIMEOUT = 4800,
  parameter int TS1_TX_COUNT        = 1024,
  parameter int TS2_TX_AFTER_RX     = 16
) (
  input logic                       clk,
  input logic                       reset,
  ltssm_tx_detect_polling_if.slave  bus
);

  localparam int CMAX = max2(max2(max2(QUIET_CYCLES, POLL_ACTIVE_TIMEOUT),
                                  max2(POLL_CONFIG_TIMEOUT, TS1_TX_COUNT)), TS2_TX_AFTER_RX);
  localparam int CW   = $clog2(CMAX + 1);

  tx_state_e           state_q;
  logic [3:0]          last_sub_q;
  logic [CW-1:0]       tmo_q, os_cnt_q, os_cnt_d;
  logic [MAXLANES-1:0] seen_q, seen_d, det_q, det_d;
  logic [4:0]          lanes_q, lanes_d;
  logic                tx_det_q, os_req_q, os_type_q, finish_q, wr_q;
  logic [3:0]          goto_q;
  logic [4:0]          nlanes_q;

  assign seen_d = seen_q | bus.phyStatus;

  lane_detect_count #(.MAXLANES(MAXLANES)) u_cnt (
    .phy_status_i (bus.phyStatus),
    .rx_status_i  (bus.rxStatus),
    .seen_i       (seen_q),
    .det_i        (det_q),
    .det_o        (det_d),
    .count_o      (lanes_d)
  );

  // TS counters saturate at their target so they can never wrap.
  always_comb begin
    os_cnt_d = os_cnt_q;
    if (state_q == ST_POLL_ACT && bus.osDone && os_cnt_q < CW'(TS1_TX_COUNT))
      os_cnt_d = os_cnt_q + 1'b1;
    else if (state_q == ST_POLL_CFG && bus.osDone && bus.ts2Received &&
             os_cnt_q < CW'(TS2_TX_AFTER_RX))
      os_cnt_d = os_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_sub_q <= SUB_NONE;
      tmo_q      <= '0;
      os_cnt_q   <= '0;
      seen_q     <= '0;
      det_q      <= '0;
      lanes_q    <= '0;
      tx_det_q   <= 1'b0;
      os_req_q   <= 1'b0;
      os_type_q  <= OS_TS1;
      finish_q   <= 1'b0;
      wr_q       <= 1'b0;
      goto_q     <= detectQuiet;
      nlanes_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      wr_q     <= 1'b0;
      if (bus.substateTx != last_sub_q) begin
        last_sub_q <= bus.substateTx;
        tmo_q      <= '0;
        os_cnt_q   <= '0;
        seen_q     <= '0;
        det_q      <= '0;
        lanes_q    <= '0;
        state_q    <= entry_state(bus.substateTx);
        tx_det_q   <= 1'b0;
        os_req_q   <= entry_state(bus.substateTx) inside {ST_POLL_ACT, ST_POLL_CFG};
        os_type_q  <= (entry_state(bus.substateTx) == ST_POLL_CFG) ? OS_TS2 : OS_TS1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            os_req_q <= 1'b0;
            tx_det_q <= 1'b0;
          end
          ST_QUIET: begin
            if (tmo_q == CW'(QUIET_CYCLES - 1)) begin
              finish_q <= 1'b1;
              goto_q   <= detectActive;
              state_q  <= ST_DONE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ST_DET_START: begin
            tx_det_q <= 1'b1;
            state_q  <= ST_DET_WAIT;
          end
          ST_DET_WAIT: begin
            seen_q <= seen_d;
            det_q  <= det_d;
            tmo_q  <= tmo_q + 1'b1;
            // Watchdog expiry without every PhyStatus is reported as zero lanes.
            if (&seen_d) begin
              tx_det_q <= 1'b0;
              lanes_q  <= lanes_d;
              state_q  <= ST_DET_RPT;
            end else if (tmo_q == CW'(QUIET_CYCLES - 1)) begin
              tx_det_q <= 1'b0;
              lanes_q  <= '0;
              state_q  <= ST_DET_RPT;
            end
          end
          ST_DET_RPT: begin
            nlanes_q <= lanes_q;
            wr_q     <= 1'b1;
            finish_q <= 1'b1;
            goto_q   <= (lanes_q != '0) ? pollingActive : detectQuiet;
            state_q  <= ST_DONE;
          end
          ST_POLL_ACT: begin
            os_req_q  <= 1'b1;
            os_type_q <= OS_TS1;
            os_cnt_q  <= os_cnt_d;
            tmo_q     <= tmo_q + 1'b1;
            if (os_cnt_d == CW'(TS1_TX_COUNT)) begin
              finish_q <= 1'b1;
              goto_q   <= pollingConfiguration;
              state_q  <= ST_DONE;
            end else if (tmo_q == CW'(POLL_ACTIVE_TIMEOUT - 1)) begin
              finish_q <= 1'b1;
              goto_q   <= detectQuiet;
              state_q  <= ST_DONE;
            end
          end
          ST_POLL_CFG: begin
            os_req_q  <= 1'b1;
            os_type_q <= OS_TS2;
            os_cnt_q  <= os_cnt_d;
            tmo_q     <= tmo_q + 1'b1;
            if (os_cnt_d == CW'(TS2_TX_AFTER_RX)) begin
              finish_q <= 1'b1;
              goto_q   <= configurationLinkWidthStart;
              state_q  <= ST_DONE;
            end else if (tmo_q == CW'(POLL_CONFIG_TIMEOUT - 1)) begin
              finish_q <= 1'b1;
              goto_q   <= detectQuiet;
              state_q  <= ST_DONE;
            end
          end
          ST_DONE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.txDetectRx                 = tx_det_q;
  assign bus.osReq                      = os_req_q;
  assign bus.osType                     = os_type_q;
  assign bus.finishTx                   = finish_q;
  assign bus.gotoTx                     = goto_q;
  assign bus.numberOfDetectedLanesOut   = nlanes_q;
  assign bus.writeNumberOfDetectedLanes = wr_q;

endmodule

// File: tb/tb_ltssm_tx_detect_polling.sv
// Bench for ltssm_tx_detect_polling: detect vectors from a table, exit decisions
// scored against a queue of expected results; hand-written polling/abort sequences.
module tb_ltssm_tx_detect_polling;
  import ltssm_pkg::*;

  localparam int ML   = 16;
  localparam int QC   = 10;
  localparam int PAT  = 40;
  localparam int PCT  = 60;
  localparam int TS1N = 8;
  localparam int TS2N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ltssm_tx_detect_polling_if #(.MAXLANES(ML)) bus();

  ltssm_tx_detect_polling #(
    .MAXLANES(ML), .QUIET_CYCLES(QC), .POLL_ACTIVE_TIMEOUT(PAT),
    .POLL_CONFIG_TIMEOUT(PCT), .TS1_TX_COUNT(TS1N), .TS2_TX_AFTER_RX(TS2N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] goto_v;
    bit         chk_cnt;
    logic [4:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] phy1;
    logic [15:0] ok1;
    logic [15:0] phy2;
    logic [15:0] ok2;
    logic [4:0]  cnt;
    logic [3:0]  goto_v;
  } det_vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3*ML-1:0] rx_vec(input logic [ML-1:0] ok);
    logic [3*ML-1:0] r;
    r = '0;
    for (int i = 0; i < ML; i++) r[3*i +: 3] = ok[i] ? 3'b011 : 3'b000;
    return r;
  endfunction

  task automatic pulse_os(output logic fin);
    bus.osDone = 1'b1;
    tick;
    fin = bus.finishTx;
    bus.osDone = 1'b0;
    tick;
    fin = fin | bus.finishTx;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic go_idle;
    bus.substateTx = 4'hF;
    tick;
    tick;
  endtask

  // Scoreboard: every finishTx pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (bus.finishTx === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected finishTx", bus.finishTx, 0);
          end else begin
            e = exp_q.pop_front();
            check("gotoTx", bus.gotoTx, e.goto_v);
            check("write strobe", bus.writeNumberOfDetectedLanes, e.chk_cnt);
            if (e.chk_cnt) check("lane count", bus.numberOfDetectedLanesOut, e.cnt);
          end
        end else if (bus.writeNumberOfDetectedLanes === 1'b1) begin
          check("stray write strobe", bus.writeNumberOfDetectedLanes, 0);
        end
      end
    end
  end

  initial begin
    det_vec_t vecs[6];
    logic     fin, early;

    vecs[0] = '{16'hFFFF, 16'h000F, 16'h0000, 16'h0000, 5'd4,  4'd2};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 5'd0,  4'd0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 5'd16, 4'd2};
    vecs[3] = '{16'h00FF, 16'h00FF, 16'h0000, 16'h0000, 5'd0,  4'd0};
    vecs[4] = '{16'h00FF, 16'hFFFF, 16'hFF01, 16'h0001, 5'd8,  4'd2};
    vecs[5] = '{16'hFFFF, 16'h8001, 16'h0000, 16'h0000, 5'd2,  4'd2};

    reset           = 1'b1;
    bus.substateTx  = 4'hF;
    bus.phyStatus   = '0;
    bus.rxStatus    = '0;
    bus.ts2Received = 1'b0;
    bus.osDone      = 1'b0;
    repeat (3) tick;
    check("reset txDetectRx", bus.txDetectRx, 0);
    check("reset osReq", bus.osReq, 0);
    check("reset finishTx", bus.finishTx, 0);
    check("reset gotoTx", bus.gotoTx, 0);
    check("reset lanes", bus.numberOfDetectedLanesOut, 0);
    check("reset write", bus.writeNumberOfDetectedLanes, 0);
    reset = 1'b0;
    tick;

    // Detect.Quiet: pulse on the 11th cycle after the change, then hold.
    bus.substateTx = 4'd0;
    exp_q.push_back('{4'd1, 1'b0, 5'd0});
    early = 1'b0;
    for (int c = 1; c <= QC; c++) begin
      tick;
      early = early | bus.finishTx;
    end
    check("quiet no early finish", early, 0);
    tick;
    check("quiet finish cycle 11", bus.finishTx, 1);
    repeat (20) tick;
    check("quiet gotoTx held", bus.gotoTx, 1);
    check("quiet single pulse", exp_q.size(), 0);

    for (int v = 0; v < 6; v++) begin
      go_idle;
      bus.substateTx = 4'd1;
      exp_q.push_back('{vecs[v].goto_v, 1'b1, vecs[v].cnt});
      tick;
      tick;
      check($sformatf("detect%0d txDetectRx on", v), bus.txDetectRx, 1);
      bus.phyStatus = vecs[v].phy1;
      bus.rxStatus  = rx_vec(vecs[v].ok1);
      tick;
      bus.phyStatus = vecs[v].phy2;
      bus.rxStatus  = rx_vec(vecs[v].ok2);
      tick;
      bus.phyStatus = '0;
      bus.rxStatus  = '0;
      wait_done($sformatf("detect%0d finish", v), QC + 10);
      check($sformatf("detect%0d txDetectRx off", v), bus.txDetectRx, 0);
    end

    // Polling.Active: exit on the cycle after the 8th TS1.
    go_idle;
    bus.substateTx = 4'd2;
    exp_q.push_back('{4'd3, 1'b0, 5'd0});
    tick;
    check("pact osReq", bus.osReq, 1);
    check("pact osType", bus.osType, 0);
    early = 1'b0;
    for (int p = 0; p < TS1N - 1; p++) begin
      pulse_os(fin);
      early = early | fin;
    end
    check("pact no early finish", early, 0);
    bus.osDone = 1'b1;
    tick;
    bus.osDone = 1'b0;
    check("pact finish after 8th", bus.finishTx, 1);
    check("pact gotoTx", bus.gotoTx, 3);
    wait_done("pact done", 4);

    go_idle;
    bus.substateTx = 4'd2;
    exp_q.push_back('{4'd0, 1'b0, 5'd0});
    wait_done("pact timeout", PAT + 10);

    // Count and timeout on the same edge: count exit wins.
    go_idle;
    bus.substateTx = 4'd2;
    exp_q.push_back('{4'd3, 1'b0, 5'd0});
    tick;
    early = 1'b0;
    for (int p = 0; p < TS1N - 1; p++) begin
      pulse_os(fin);
      early = early | fin;
    end
    repeat (PAT - 1 - 2 * (TS1N - 1)) tick;
    check("tie no early finish", early | bus.finishTx, 0);
    bus.osDone = 1'b1;
    tick;
    bus.osDone = 1'b0;
    check("tie finish", bus.finishTx, 1);
    check("tie gotoTx", bus.gotoTx, 3);
    wait_done("tie done", 4);

    // Polling.Configuration: only osDone with ts2Received counts.
    go_idle;
    bus.substateTx = 4'd3;
    exp_q.push_back('{4'd4, 1'b0, 5'd0});
    tick;
    check("pcfg osReq", bus.osReq, 1);
    check("pcfg osType", bus.osType, 1);
    early = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse_os(fin);
      early = early | fin;
    end
    bus.ts2Received = 1'b1;
    for (int p = 0; p < TS2N - 1; p++) begin
      pulse_os(fin);
      early = early | fin;
    end
    check("pcfg no early finish", early, 0);
    bus.osDone = 1'b1;
    tick;
    bus.osDone = 1'b0;
    check("pcfg finish after 4th", bus.finishTx, 1);
    bus.ts2Received = 1'b0;
    wait_done("pcfg done", 4);

    // Abort mid Polling.Active restarts the TS1 count.
    go_idle;
    bus.substateTx = 4'd2;
    tick;
    for (int p = 0; p < 5; p++) pulse_os(fin);
    bus.substateTx = 4'd0;
    tick;
    tick;
    bus.substateTx = 4'd2;
    exp_q.push_back('{4'd3, 1'b0, 5'd0});
    tick;
    early = 1'b0;
    for (int p = 0; p < TS1N - 1; p++) begin
      pulse_os(fin);
      early = early | fin;
    end
    check("restart no early finish", early, 0);
    bus.osDone = 1'b1;
    tick;
    bus.osDone = 1'b0;
    check("restart finish after 8th", bus.finishTx, 1);
    wait_done("restart done", 4);

    // Reset in DET_WAIT drops txDetectRx on the next cycle.
    go_idle;
    bus.substateTx = 4'd1;
    tick;
    tick;
    check("detwait txDetectRx", bus.txDetectRx, 1);
    reset = 1'b1;
    tick;
    check("reset mid detwait txDetectRx", bus.txDetectRx, 0);
    bus.substateTx = 4'hF;
    tick;
    reset = 1'b0;
    repeat (3) tick;
    check("post reset idle osReq", bus.osReq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
